// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational RV32I ALU between two requesters.
// Each granted op takes three cycles: grant/latch, execute/capture, done pulse.
module alu_arbiter #(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [4:0]  op0,
    input  logic [4:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        flag,
    output logic        busy,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_res,
    input  logic        alu_zero
);

    localparam logic [4:0] OP_NOP = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t r_state;
    logic   r_prio;
    logic   r_sel;

    logic   w_pick1;
    logic   w_is_branch;

    // Port 1 wins when it is the only requester or when both request and it holds priority.
    assign w_pick1     = req1 && (!req0 || r_prio);
    assign w_is_branch = (alu_op >= 5'b00011) && (alu_op <= 5'b01000);

    // The ALU drive registers double as the operand registers; they are only
    // non-NOP while in EXEC, so the ALU sees exactly the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= (FIRST_PRIO != 0);
            r_sel   <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            result  <= '0;
            flag    <= 1'b0;
            busy    <= 1'b0;
            alu_op  <= OP_NOP;
            alu_in1 <= '0;
            alu_in2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (req0 || req1) begin
                        r_sel   <= w_pick1;
                        alu_op  <= w_pick1 ? op1 : op0;
                        alu_in1 <= w_pick1 ? a1 : a0;
                        alu_in2 <= w_pick1 ? b1 : b0;
                        busy    <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The ALU zero output is stale for non-branch ops, so it is masked.
                    if (w_is_branch) begin
                        result <= '0;
                        flag   <= alu_zero;
                    end else begin
                        result <= alu_res;
                        flag   <= 1'b0;
                    end
                    alu_op  <= OP_NOP;
                    alu_in1 <= '0;
                    alu_in2 <= '0;
                    done0   <= !r_sel;
                    done1   <= r_sel;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    busy    <= 1'b0;
                    r_prio  <= !r_sel;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU whose
// zero output holds its last branch result across non-branch ops.
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_BEQ  = 5'b00011;
    localparam logic [4:0] OP_BNE  = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00101;
    localparam logic [4:0] OP_BGE  = 5'b00110;
    localparam logic [4:0] OP_BLTU = 5'b00111;
    localparam logic [4:0] OP_BGEU = 5'b01000;
    localparam logic [4:0] OP_SUB  = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_SLL  = 5'b01101;
    localparam logic [4:0] OP_NOP  = 5'b10010;
    localparam logic [4:0] OP_ILL  = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [4:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic        done0, done1, flag, busy;
    logic [31:0] result, alu_in1, alu_in2;
    logic [4:0]  alu_op;
    logic [31:0] m_res;
    logic        m_cond;
    logic        m_hold = 1'b0;
    logic        m_is_br;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .done0(done0), .done1(done1),
        .result(result), .flag(flag), .busy(busy),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_res(m_res), .alu_zero(alu_zero)
    );

    // Behavioural ALU; zero only updates on branch ops and is held otherwise.
    always_comb begin
        m_res  = '0;
        m_cond = 1'b0;
        case (alu_op)
            OP_ADD:  m_res = alu_in1 + alu_in2;
            OP_SUB:  m_res = alu_in1 - alu_in2;
            OP_XOR:  m_res = alu_in1 ^ alu_in2;
            OP_SLL:  m_res = alu_in1 << alu_in2[4:0];
            OP_NOP:  m_res = alu_in1 + alu_in2;
            OP_BEQ:  m_cond = (alu_in1 == alu_in2);
            OP_BNE:  m_cond = (alu_in1 != alu_in2);
            OP_BLT:  m_cond = ($signed(alu_in1) < $signed(alu_in2));
            OP_BGE:  m_cond = ($signed(alu_in1) >= $signed(alu_in2));
            OP_BLTU: m_cond = (alu_in1 < alu_in2);
            OP_BGEU: m_cond = (alu_in1 >= alu_in2);
            default: m_res = '0;
        endcase
    end
    assign m_is_br  = (alu_op >= OP_BEQ) && (alu_op <= OP_BGEU);
    assign alu_zero = m_is_br ? m_cond : m_hold;
    always @(posedge clk) if (m_is_br) m_hold <= m_cond;

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        op0 = OP_ADD; a0 = 32'd3; b0 = 32'd4;
        op1 = OP_NOP; a1 = '0; b1 = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({done0, done1, busy, flag} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {done0, done1, busy, flag});
        end
        n_checks++;
        if (alu_op !== OP_NOP || alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: op=%b in1=%h in2=%h res=%h want op=10010 rest 0",
                     alu_op, alu_in1, alu_in2, result);
        end
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || alu_op !== OP_ADD || alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_exec: busy=%b op=%b in1=%h in2=%h done0=%b want 1 00010 5 7 0",
                     busy, alu_op, alu_in1, alu_in2, done0);
        end
        a0 = 32'hDEAD_0000; op0 = OP_SUB;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || result !== 32'd12 || flag !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: d0=%b d1=%b res=%0d flag=%b want 1 0 12 0", done0, done1, result, flag);
        end
        req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || busy !== 1'b0 || result !== 32'd12) begin
            n_fail++;
            $display("FAIL add_after: d0=%b busy=%b res=%0d want 0 0 12", done0, busy, result);
        end
    endtask

    task automatic test_branch();
        logic [4:0] ops [2];
        logic       exp_flag [2];
        ops[0] = OP_BLT;  exp_flag[0] = 1'b1;
        ops[1] = OP_BLTU; exp_flag[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req1 = 1'b1; op1 = ops[i]; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (done1 !== 1'b1 || done0 !== 1'b0 || flag !== exp_flag[i] || result !== 32'd0) begin
                n_fail++;
                $display("FAIL branch_%0d: d1=%b d0=%b flag=%b res=%h want 1 0 %b 0",
                         i, done1, done0, flag, result, exp_flag[i]);
            end
            req1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        logic exp0, exp1;
        do_reset();
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1; b0 = 32'd1;
        req1 = 1'b1; op1 = OP_SUB; a1 = 32'd9; b1 = 32'd4;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp0 = (k == 2) || (k == 8);
            exp1 = (k == 5);
            n_checks++;
            if (done0 !== exp0 || done1 !== exp1) begin
                n_fail++;
                $display("FAIL contend_done_c%0d: d0=%b d1=%b want %b %b", k, done0, done1, exp0, exp1);
            end
            if (exp0 || exp1) begin
                n_checks++;
                if (result !== (exp0 ? 32'd2 : 32'd5)) begin
                    n_fail++;
                    $display("FAIL contend_res_c%0d: got %0d want %0d", k, result, exp0 ? 2 : 5);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stale_zero();
        logic [4:0]  ops [2];
        logic [31:0] as [2], bs [2], exp_res [2];
        logic        exp_flag [2];
        ops[0] = OP_BEQ; as[0] = 32'd3;      bs[0] = 32'd3;      exp_res[0] = 32'd0;      exp_flag[0] = 1'b1;
        ops[1] = OP_XOR; as[1] = 32'hF0F0;   bs[1] = 32'h0FF0;   exp_res[1] = 32'hFF00;   exp_flag[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0 = 1'b1; op0 = ops[i]; a0 = as[i]; b0 = bs[i];
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (done0 !== 1'b1 || result !== exp_res[i] || flag !== exp_flag[i]) begin
                n_fail++;
                $display("FAIL stale_%0d: d0=%b res=%h flag=%b want 1 %h %b",
                         i, done0, result, flag, exp_res[i], exp_flag[i]);
            end
            req0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_shift_illegal();
        logic [4:0]  ops [2];
        logic [31:0] bs [2], exp_res [2];
        ops[0] = OP_SLL; bs[0] = 32'd33; exp_res[0] = 32'd2;
        ops[1] = OP_ILL; bs[1] = 32'd5;  exp_res[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            req1 = 1'b1; op1 = ops[i]; a1 = 32'd1; b1 = bs[i];
            @(negedge clk);
            n_checks++;
            if (alu_in2 !== bs[i]) begin
                n_fail++; $display("FAIL shift_b_%0d: in2=%h want %h", i, alu_in2, bs[i]);
            end
            @(negedge clk);
            n_checks++;
            if (done1 !== 1'b1 || result !== exp_res[i] || flag !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_%0d: d1=%b res=%h flag=%b want 1 %h 0", i, done1, result, flag, exp_res[i]);
            end
            req1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_exec();
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd20; b0 = 32'd22;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || busy !== 1'b0 || alu_op !== OP_NOP || result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_exec: d0=%b busy=%b op=%b res=%h want 0 0 10010 0", done0, busy, alu_op, result);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || busy !== 1'b1 || alu_in1 !== 32'd20) begin
            n_fail++; $display("FAIL rst_reexec: d0=%b busy=%b in1=%0d want 0 1 20", done0, busy, alu_in1);
        end
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || result !== 32'd42) begin
            n_fail++; $display("FAIL rst_redone: d0=%b res=%0d want 1 42", done0, result);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_contention();
        test_stale_zero();
        test_shift_illegal();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
